// File: rtl/demux1_2_buf.sv
// demux1_2_buf: 1-to-2 demultiplexer with an independent DEPTH-entry FIFO
// behind each output port. Words are routed by in_sel at acceptance, each
// port preserves its own word order, and each port counts delivered words.
// DEPTH must be 2 or 4 so that the pointers wrap naturally at a power of two.
module demux1_2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [7:0]       out0_count,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [7:0]       out1_count
);

  // Pointer width and occupancy width (occupancy must be able to hold DEPTH).
  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;

  // Per-port status and handshake vectors, index 0 = port 0, 1 = port 1.
  logic [1:0]       full;
  logic [1:0]       empty;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       out_ready_vec;
  logic [WIDTH-1:0] head      [2];
  logic [7:0]       count_vec [2];

  assign out_ready_vec = {out1_ready, out0_ready};

  // Readiness depends only on the selected FIFO's registered fullness, so a
  // full FIFO being popped this cycle still refuses the push; the freed slot
  // is offered from the next cycle on.
  assign in_ready = ~full[in_sel];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [WIDTH-1:0] mem_reg [DEPTH];
      logic [PW-1:0]    wr_ptr_reg;
      logic [PW-1:0]    wr_ptr_next;
      logic [PW-1:0]    rd_ptr_reg;
      logic [PW-1:0]    rd_ptr_next;
      logic [CW-1:0]    occ_reg;
      logic [CW-1:0]    occ_next;
      logic [7:0]       count_reg;
      logic [7:0]       count_next;

      assign full[gi]  = (occ_reg == CW'(DEPTH));
      assign empty[gi] = (occ_reg == '0);

      // A push lands here only when this port is the selected destination.
      assign push[gi] = in_valid & in_ready & (in_sel == 1'(gi));
      // Popping an empty FIFO is a no-op, so the ready is qualified by valid.
      assign pop[gi]  = ~empty[gi] & out_ready_vec[gi];

      // Next-state for pointers, occupancy and delivered-word count.
      always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        occ_next    = occ_reg;
        count_next  = count_reg;
        if (push[gi]) begin
          wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (pop[gi]) begin
          rd_ptr_next = rd_ptr_reg + PW'(1);
          count_next  = count_reg + 8'd1;
        end
        case ({push[gi], pop[gi]})
          2'b10:   occ_next = occ_reg + CW'(1);
          2'b01:   occ_next = occ_reg - CW'(1);
          default: occ_next = occ_reg;
        endcase
      end

      // Control state; reset takes effect immediately, independent of clk.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          occ_reg    <= '0;
          count_reg  <= '0;
        end else begin
          wr_ptr_reg <= wr_ptr_next;
          rd_ptr_reg <= rd_ptr_next;
          occ_reg    <= occ_next;
          count_reg  <= count_next;
        end
      end

      // Storage; cleared on reset so the head reads zero until the first push.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
          end
        end else if (push[gi]) begin
          mem_reg[wr_ptr_reg] <= in_data;
        end
      end

      assign head[gi]      = mem_reg[rd_ptr_reg];
      assign count_vec[gi] = count_reg;
    end
  endgenerate

  assign out0_valid = ~empty[0];
  assign out1_valid = ~empty[1];
  assign out0_data  = head[0];
  assign out1_data  = head[1];
  assign out0_count = count_vec[0];
  assign out1_count = count_vec[1];

endmodule

// File: tb/tb_demux1_2_buf.sv
// Testbench for demux1_2_buf: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the two port buffers.
module tb_demux1_2_buf;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic [7:0]       out0_count;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [7:0]       out1_count;

  demux1_2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data), .out0_count(out0_count),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data), .out1_count(out1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: one word queue and one delivered-count per port.
  logic [WIDTH-1:0] q0 [$];
  logic [WIDTH-1:0] q1 [$];
  logic [7:0]       m_cnt0 = 8'd0;
  logic [7:0]       m_cnt1 = 8'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int occ(input logic sel);
    return sel ? q1.size() : q0.size();
  endfunction

  // Apply one clock edge to the model using the inputs held across the edge.
  task automatic model_edge();
    logic acc;
    if (!rst_n) return;
    acc = in_valid && (occ(in_sel) < DEPTH);
    if (out0_ready && q0.size() > 0) begin
      $display("pop  port0 data=%h", q0[0]);
      void'(q0.pop_front());
      m_cnt0 = m_cnt0 + 8'd1;
    end
    if (out1_ready && q1.size() > 0) begin
      $display("pop  port1 data=%h", q1[0]);
      void'(q1.pop_front());
      m_cnt1 = m_cnt1 + 8'd1;
    end
    if (acc) begin
      $display("push port%0d data=%h", in_sel, in_data);
      if (in_sel) q1.push_back(in_data);
      else        q0.push_back(in_data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("in_ready", {63'd0, in_ready}, {63'd0, occ(in_sel) < DEPTH});
    check("out0_valid", {63'd0, out0_valid}, {63'd0, q0.size() > 0});
    check("out1_valid", {63'd0, out1_valid}, {63'd0, q1.size() > 0});
    if (q0.size() > 0) check("out0_data", {32'd0, out0_data}, {32'd0, q0[0]});
    if (q1.size() > 0) check("out1_data", {32'd0, out1_data}, {32'd0, q1[0]});
    check("out0_count", {56'd0, out0_count}, {56'd0, m_cnt0});
    check("out1_count", {56'd0, out1_count}, {56'd0, m_cnt1});
  end

  logic [7:0] base0;
  logic [7:0] base1;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    // Reset state while held in reset.
    check("rst_out0_valid", {63'd0, out0_valid}, 64'd0);
    check("rst_out1_valid", {63'd0, out1_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out0_data", {32'd0, out0_data}, 64'd0);
    check("rst_out1_data", {32'd0, out1_data}, 64'd0);
    check("rst_out0_count", {56'd0, out0_count}, 64'd0);
    rst_n = 1'b1;

    // Routing: first edge after reset accepts, one-cycle latency per port.
    drive(1'b1, 1'b0, 32'h12345678, 1'b1, 1'b1);
    tick();
    check("route_out0_valid", {63'd0, out0_valid}, 64'd1);
    check("route_out0_data", {32'd0, out0_data}, 64'h12345678);
    drive(1'b1, 1'b1, 32'h87654321, 1'b1, 1'b1);
    tick();
    check("route_out1_data", {32'd0, out1_data}, 64'h87654321);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tick();
    check("route_out0_count", {56'd0, out0_count}, 64'd1);
    check("route_out1_count", {56'd0, out1_count}, 64'd1);

    // Backpressure: port 0 fills after two words, third is held.
    drive(1'b1, 1'b0, 32'hA0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'hA2, 1'b0, 1'b0);
    check("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
    tick();
    check("bp_held_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_head", {32'd0, out0_data}, 64'hA0);
    in_sel = 1'b1;
    #1;
    check("bp_other_port_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick();
    tick();

    // Order and hold on port 1.
    drive(1'b1, 1'b1, 32'hB1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'hB2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    check("hold_out1_data", {32'd0, out1_data}, 64'hB1);
    out1_ready = 1'b1;
    tick();
    check("order_second", {32'd0, out1_data}, 64'hB2);
    tick();
    check("order_drained", {63'd0, out1_valid}, 64'd0);

    // Concurrency: push+pop at occupancy 1, then push one port / pop the other.
    drive(1'b1, 1'b0, 32'hC1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'hC2, 1'b1, 1'b0);
    tick();
    check("conc_occ_valid", {63'd0, out0_valid}, 64'd1);
    check("conc_new_head", {32'd0, out0_data}, 64'hC2);
    drive(1'b1, 1'b1, 32'hD1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'hC3, 1'b0, 1'b1);
    tick();
    check("conc_pop_other", {63'd0, out1_valid}, 64'd0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tick();
    tick();
    tick();

    // Count wrap: exactly 256 pops on port 0.
    base0 = m_cnt0;
    base1 = m_cnt1;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, $urandom, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick();
    check("wrap_out0_count", {56'd0, out0_count}, {56'd0, base0});
    check("wrap_out1_count", {56'd0, out1_count}, {56'd0, base1});

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      tick();
    end

    // Async reset between edges with both FIFOs holding data.
    drive(1'b1, 1'b0, 32'hE0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'hE1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("arst_out0_valid", {63'd0, out0_valid}, 64'd0);
    check("arst_out1_valid", {63'd0, out1_valid}, 64'd0);
    check("arst_out0_count", {56'd0, out0_count}, 64'd0);
    check("arst_out1_count", {56'd0, out1_count}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    q0.delete();
    q1.delete();
    m_cnt0 = 8'd0;
    m_cnt1 = 8'd0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      tick();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux1_2_buf.md
DEMUX1_2_BUF -- requirements
Module: demux1_2_buf

Interface
REQ-001 Parameter WIDTH, default 32, data width of every data port.
REQ-002 Parameter DEPTH, default 2, entries per output buffer; legal values 2 and 4 only.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream offers a word this cycle.
REQ-006 in_ready  output  1  block accepts the offered word this cycle.
REQ-007 in_sel  input  1  destination of the offered word: 0 -> port 0, 1 -> port 1.
REQ-008 in_data  input  WIDTH  offered word.
REQ-009 out0_valid / out1_valid  output  1  head entry of that port's buffer is present.
REQ-010 out0_ready / out1_ready  input  1  downstream consumes the head entry this cycle.
REQ-011 out0_data / out1_data  output  WIDTH  head entry of that port's buffer.
REQ-012 out0_count / out1_count  output  8  words delivered on that port since reset.

Function
REQ-013 Each output port SHALL own an independent FIFO of DEPTH entries; a word SHALL be delivered only on the port named by in_sel at acceptance.
REQ-014 Acceptance: in_valid && in_ready at a rising edge; the word SHALL be written into the FIFO selected by in_sel.
REQ-015 in_ready SHALL equal NOT full of the FIFO selected by in_sel, with no combinational path from out0_ready or out1_ready.
REQ-016 Latency: a word accepted at edge N into an empty FIFO SHALL appear on outX_data with outX_valid=1 after edge N, i.e. in cycle N+1; there is no same-cycle bypass.
REQ-017 outX_valid SHALL be 1 exactly when FIFO X is non-empty; outX_data SHALL be the oldest entry, and SHALL be held stable while outX_valid=1 and outX_ready=0.
REQ-018 Pop: outX_valid && outX_ready at an edge SHALL remove the head entry; outX_ready while empty SHALL have no effect.
REQ-019 Push to FIFO X while full SHALL not occur, because in_ready=0; in_valid with in_ready=0 SHALL change no state.
REQ-020 Simultaneous push and pop on the same FIFO SHALL leave occupancy unchanged and preserve order; this is also legal at occupancy 0 only if the push comes after the pop, i.e. the pop is a no-op.
REQ-021 A full FIFO SHALL not accept a push in the cycle it is popped; the freed entry becomes available from the next cycle.
REQ-022 A push into one port and a pop from the other port in the same cycle SHALL both take effect.
REQ-023 Word order SHALL be preserved per port; there is no ordering relation between ports.
REQ-024 outX_count SHALL increment by 1 on each pop of FIFO X and wrap 255 -> 0.
REQ-025 FIFO read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-026 When rst_n=0, the block SHALL immediately, without waiting for clk, empty both FIFOs and drive out0_valid=0, out1_valid=0, out0_count=0 and out1_count=0.
REQ-027 in_ready SHALL equal 1 while rst_n=0 and after reset, since both FIFOs are empty.
REQ-028 outX_data SHALL read 0 after reset until the first push.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered words; no word accepted before reset SHALL appear after it.
REQ-030 The first edge with rst_n=1 SHALL be able to accept a word.

Verification
REQ-031 Routing: after reset, drive in_sel=0, in_data=32'h12345678, then in_sel=1, in_data=32'h87654321, with both ready=1 -> out0_data=12345678 one cycle after the first acceptance, out1_data=87654321 one cycle after the second; each count=1.
REQ-032 Backpressure: out0_ready=0, push 3 words with sel=0 and DEPTH=2 -> in_ready=0 after 2 acceptances, the 3rd is held; in_sel=1 in the same cycle -> in_ready=1.
REQ-033 Order and hold: fill port 1 with A1, A2, then toggle out1_ready -> out1_data stays A1 while stalled, then delivers A1 and A2 in that order, and out1_valid drops after A2.
REQ-034 Concurrency: port 0 at occupancy 1, push sel=0 and pop port 0 in the same edge -> occupancy stays 1 and the next head is the new word; push to port 0 while popping port 1 -> both take effect.
REQ-035 Count wrap: 256 pops on port 0 -> out0_count returns to 0; out1_count is unchanged.
REQ-036 Async reset: with both FIFOs holding data, pulse rst_n low between clock edges -> both valid outputs and both counts are 0 before the next edge, and no old word appears afterward.
